// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester onto a UART transmitter for a
// whole packet, revoking the grant if the owner stalls for too long.
module uart_tx_arbiter #(
  parameter int num_req_p        = 4,
  parameter int data_bits_p      = 8,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*data_bits_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]             req_last_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic                             tx_v_o,
  output logic [data_bits_p-1:0]           tx_data_o,
  input  logic                             tx_ready_i,
  output logic [num_req_p-1:0]             grant_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  localparam int idx_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int stall_w_lp = (timeout_cycles_p > 0) ? $clog2(timeout_cycles_p + 1) : 1;
  localparam logic [stall_w_lp-1:0] thresh_lp =
    (timeout_cycles_p > 0) ? stall_w_lp'(timeout_cycles_p - 1) : '0;
  localparam logic [idx_w_lp:0] num_req_lp = (idx_w_lp + 1)'(num_req_p);

  typedef enum logic {e_idle, e_lock} state_e;

  state_e                state_q, state_d;
  logic [idx_w_lp-1:0]   grant_idx_q, grant_idx_d;
  logic [idx_w_lp-1:0]   ptr_q, ptr_d;
  logic [stall_w_lp-1:0] stall_q, stall_d;
  logic                  timeout_q, timeout_d;

  logic [data_bits_p-1:0] req_byte [num_req_p];

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign req_byte[gi] = req_data_i[gi*data_bits_p +: data_bits_p];
    assign grant_o[gi]  = (state_q == e_lock) && (grant_idx_q == idx_w_lp'(gi));
  end

  // Round-robin search starting at ptr_q, wrapping modulo num_req_p.
  logic                pick_found;
  logic [idx_w_lp-1:0] pick_idx;
  logic [idx_w_lp:0]   rr_sum;
  logic [idx_w_lp-1:0] rr_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_idx     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rr_sum = {1'b0, ptr_q} + (idx_w_lp + 1)'(i);
      if (rr_sum >= num_req_lp) begin
        rr_sum = rr_sum - num_req_lp;
      end
      rr_idx = rr_sum[idx_w_lp-1:0];
      if (!pick_found && req_v_i[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  logic [idx_w_lp:0]   next_sum;
  logic [idx_w_lp-1:0] grant_next_idx;

  always_comb begin
    next_sum = {1'b0, grant_idx_q} + (idx_w_lp + 1)'(1);
    if (next_sum >= num_req_lp) begin
      next_sum = '0;
    end
    grant_next_idx = next_sum[idx_w_lp-1:0];
  end

  logic owner_v;
  logic beat;

  assign owner_v = req_v_i[grant_idx_q];
  assign beat    = owner_v && tx_ready_i;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    stall_d     = stall_q;
    timeout_d   = 1'b0;
    tx_v_o      = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;

    case (state_q)
      e_idle: begin
        stall_d = '0;
        if (pick_found) begin
          state_d     = e_lock;
          grant_idx_d = pick_idx;
        end
      end

      e_lock: begin
        tx_v_o                   = owner_v;
        tx_data_o                = owner_v ? req_byte[grant_idx_q] : '0;
        req_ready_o[grant_idx_q] = tx_ready_i;
        if (beat) begin
          stall_d = '0;
          if (req_last_i[grant_idx_q]) begin
            state_d = e_idle;
            ptr_d   = grant_next_idx;
          end
        end else if (!owner_v) begin
          // Backpressure with valid data held is not a stall; only a silent owner is.
          if ((timeout_cycles_p > 0) && (stall_q == thresh_lp)) begin
            state_d   = e_idle;
            ptr_d     = grant_next_idx;
            stall_d   = '0;
            timeout_d = 1'b1;
          end else if (stall_q != '1) begin
            stall_d = stall_q + stall_w_lp'(1);
          end
        end
      end

      default: begin
        state_d = e_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      stall_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      stall_q     <= stall_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_o    = (state_q == e_lock);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: contention, mid-packet fairness, backpressure, timeout,
// beat-on-threshold and asynchronous reset.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  req_v, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_v, tx_ready, busy, tout;
  logic [7:0]  tx_data;

  logic [3:0]  b_req_v, b_req_last, b_req_ready, b_grant;
  logic [31:0] b_req_data;
  logic        b_tx_v, b_tx_ready, b_busy, b_tout;
  logic [7:0]  b_tx_data;

  uart_tx_arbiter #(.num_req_p(4), .data_bits_p(8), .timeout_cycles_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_v_o(tx_v), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy), .timeout_o(tout)
  );

  uart_tx_arbiter #(.num_req_p(4), .data_bits_p(8), .timeout_cycles_p(1024)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(b_req_v), .req_data_i(b_req_data), .req_last_i(b_req_last),
    .req_ready_o(b_req_ready), .tx_v_o(b_tx_v), .tx_data_o(b_tx_data),
    .tx_ready_i(b_tx_ready), .grant_o(b_grant), .busy_o(b_busy), .timeout_o(b_tout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int         src_cnt  [4];
  int         src_len  [4];
  logic [7:0] src_base [4];
  logic       use_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet source model: each requester streams base+index until its length is used up.
  task automatic drive_srcs();
    if (use_model) begin
      for (int k = 0; k < 4; k++) begin
        req_v[k]            = (src_cnt[k] < src_len[k]);
        req_data[k*8 +: 8]  = src_base[k] + 8'(src_cnt[k]);
        req_last[k]         = (src_cnt[k] == src_len[k] - 1);
      end
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic b, input logic v,
                      input logic [7:0] d, input logic [3:0] r, input logic t);
    @(negedge clk);
    chk({tag, ".grant"},   32'(grant),     32'(g));
    chk({tag, ".busy"},    32'(busy),      32'(b));
    chk({tag, ".tx_v"},    32'(tx_v),      32'(v));
    chk({tag, ".tx_data"}, 32'(tx_data),   32'(d));
    chk({tag, ".ready"},   32'(req_ready), 32'(r));
    chk({tag, ".timeout"}, 32'(tout),      32'(t));
    $display("cycle %s: grant=%b busy=%b tx_v=%b tx_data=%h ready=%b timeout=%b",
             tag, grant, busy, tx_v, tx_data, req_ready, tout);
    if (use_model) begin
      for (int k = 0; k < 4; k++) begin
        if (req_v[k] && req_ready[k]) src_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    drive_srcs();
  endtask

  initial begin
    reset_n    = 1'b0;
    req_v      = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    b_req_v    = '0; b_req_last = '0; b_req_data = '0; b_tx_ready = 1'b0;
    use_model  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_cnt[k]  = 0;
      src_len[k]  = 0;
      src_base[k] = 8'hA0 + 8'(k * 16);
    end

    // Reset state
    @(negedge clk);
    chk("reset.grant", 32'(grant), 32'h0);
    chk("reset.busy",  32'(busy),  32'h0);
    chk("reset.tx_v",  32'(tx_v),  32'h0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    chk("reset.timeout", 32'(tout), 32'h0);
    chk("reset.b_busy", 32'(b_busy), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Backpressure on the 1024-cycle instance: 2000 cycles, no timeout, data stable
    b_req_v = 4'b0001; b_req_data = 32'h0000_003C; b_req_last = 4'b0001; b_tx_ready = 1'b0;
    @(negedge clk);
    chk("bp.idle_busy", 32'(b_busy), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      chk("bp.busy",    32'(b_busy),    32'h1);
      chk("bp.tx_v",    32'(b_tx_v),    32'h1);
      chk("bp.tx_data", 32'(b_tx_data), 32'h3C);
      chk("bp.timeout", 32'(b_tout),    32'h0);
      @(posedge clk); #1;
    end
    $display("cycle bp: 2000 backpressure cycles busy=%b tx_data=%h", b_busy, b_tx_data);
    b_tx_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_ready", 32'(b_req_ready), 32'h1);
    @(posedge clk); #1;
    b_req_v = '0; b_req_last = '0; b_tx_ready = 1'b0;
    @(negedge clk);
    chk("bp.done_busy", 32'(b_busy), 32'h0);
    @(posedge clk); #1;

    // Contention: four 2-byte packets, granted 0,1,2,3 with one idle cycle between
    use_model = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_cnt[k] = 0;
      src_len[k] = 2;
    end
    drive_srcs();
    outs("ct.arb0",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("ct.r0b0",  4'b0001, 1, 1, 8'hA0, 4'b0001, 0);
    outs("ct.r0b1",  4'b0001, 1, 1, 8'hA1, 4'b0001, 0);
    outs("ct.arb1",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("ct.r1b0",  4'b0010, 1, 1, 8'hB0, 4'b0010, 0);
    outs("ct.r1b1",  4'b0010, 1, 1, 8'hB1, 4'b0010, 0);
    outs("ct.arb2",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("ct.r2b0",  4'b0100, 1, 1, 8'hC0, 4'b0100, 0);
    outs("ct.r2b1",  4'b0100, 1, 1, 8'hC1, 4'b0100, 0);
    outs("ct.arb3",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("ct.r3b0",  4'b1000, 1, 1, 8'hD0, 4'b1000, 0);
    outs("ct.r3b1",  4'b1000, 1, 1, 8'hD1, 4'b1000, 0);
    outs("ct.drain", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    // Mid-packet fairness: requester 0 arrives during byte 1 of requester 2's packet
    for (int k = 0; k < 4; k++) begin
      src_cnt[k] = 0;
      src_len[k] = (k == 2) ? 3 : 0;
    end
    drive_srcs();
    outs("mp.arb",   4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("mp.r2b0",  4'b0100, 1, 1, 8'hC0, 4'b0100, 0);
    src_cnt[0] = 0; src_len[0] = 1;
    drive_srcs();
    outs("mp.r2b1",  4'b0100, 1, 1, 8'hC1, 4'b0100, 0);
    outs("mp.r2b2",  4'b0100, 1, 1, 8'hC2, 4'b0100, 0);
    outs("mp.arb0",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("mp.r0b0",  4'b0001, 1, 1, 8'hA0, 4'b0001, 0);
    outs("mp.drain", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    // Timeout (16): requester 1 sends one byte then goes silent
    use_model = 1'b0;
    req_data = 32'hD3C2_5AA0; req_v = 4'b0010; req_last = '0; tx_ready = 1'b1;
    outs("to.arb",  4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("to.b0",   4'b0010, 1, 1, 8'h5A, 4'b0010, 0);
    req_v = '0;
    for (int i = 0; i < 16; i++) begin
      outs($sformatf("to.stall%0d", i), 4'b0010, 1, 0, 8'h00, 4'b0010, 0);
    end
    req_v = 4'b1111; req_last = 4'b0100;
    outs("to.pulse", 4'b0000, 0, 0, 8'h00, 4'b0000, 1);
    outs("to.ptr2",  4'b0100, 1, 1, 8'hC2, 4'b0100, 0);

    // Beat on the threshold cycle wins over the timeout
    req_v = 4'b0010; req_last = '0;
    outs("th.arb", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    outs("th.b0",  4'b0010, 1, 1, 8'h5A, 4'b0010, 0);
    req_v = '0;
    for (int i = 0; i < 15; i++) begin
      outs($sformatf("th.stall%0d", i), 4'b0010, 1, 0, 8'h00, 4'b0010, 0);
    end
    req_v = 4'b0010; req_last = 4'b0010;
    outs("th.beat", 4'b0010, 1, 1, 8'h5A, 4'b0010, 0);
    req_v = '0; req_last = '0;
    outs("th.after", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    // Async reset mid-packet, then restart from requester 0
    req_v = 4'b0100;
    outs("ar.arb", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    #2;
    chk("ar.locked_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("ar.grant",   32'(grant),     32'h0);
    chk("ar.busy",    32'(busy),      32'h0);
    chk("ar.tx_v",    32'(tx_v),      32'h0);
    chk("ar.tx_data", 32'(tx_data),   32'h0);
    chk("ar.ready",   32'(req_ready), 32'h0);
    chk("ar.timeout", 32'(tout),      32'h0);
    $display("cycle ar.reset: grant=%b busy=%b tx_v=%b", grant, busy, tx_v);
    @(posedge clk); #1;
    reset_n = 1'b1; req_v = 4'b1111; req_last = 4'b1111;
    outs("ar.rearb", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    req_v = '0;
    req_v[0] = 1'b1;
    outs("ar.r0",    4'b0001, 1, 1, 8'hA0, 4'b0001, 0);
    req_v = '0; req_last = '0;
    outs("ar.end",   4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
